data_mem_ctrl: RTL
==================

// Module: data_mem_ctrl
// PURPOSE
//  Data-memory controller feeding the memory stage: services MemRead/MemWrite from EX/MEM.
//  Returns ReadDataM, which is consumed by the MEM/WB pipe register.
//  Two regions: internal word RAM (sync read) and a camera/peripheral window behind a req/ack handshake.
//  Asserts StallM to freeze the pipeline while an access is in flight.
// PARAMETERS
//  ADDR_BITS  10             word-address width of internal RAM (depth = 2**ADDR_BITS words)
//  CAM_BASE   32'h0001_0000  byte addresses >= CAM_BASE route to camera port; below go to RAM
//  TIMEOUT    16             max cycles to wait for cam_ack before erroring (>=2)
// PORTS
//  clk         in   1   rising-edge clock
//  reset       in   1   synchronous, active-high reset
//  MemReadM    in   1   load request from EX/MEM
//  MemWriteM   in   1   store request from EX/MEM
//  AddrM       in   32  byte address (ALU result)
//  WriteDataM  in   32  store data
//  ReadDataM   out  32  load data to memory stage / MEM/WB register
//  StallM      out  1   1 = hold all upstream pipe registers and inputs stable
//  ErrM        out  1   one-cycle pulse: camera access timed out
//  cam_req     out  1   camera request, held until ack or timeout
//  cam_we      out  1   1 = write, 0 = read (valid while cam_req)
//  cam_addr    out  32  byte address (valid while cam_req)
//  cam_wdata   out  32  store data (valid while cam_req)
//  cam_ack     in   1   camera completion, single-cycle pulse
//  cam_rdata   in   32  read data, valid with cam_ack
// BEHAVIOUR
//  Reset: state=IDLE, timeout cnt=0; ReadDataM=0, StallM=0, ErrM=0.
//   Camera outputs cleared: cam_req=0, cam_we=0, cam_addr=0, cam_wdata=0.
//   RAM contents not cleared.
//  Reset mid-transaction: abort at that edge; cam_req low next cycle; late cam_ack ignored.
//  RAM index = AddrM[ADDR_BITS+1:2]; AddrM[1:0] ignored; upper bits below CAM_BASE alias (wrap).
//  MemWriteM & MemReadM together: treated as write only.
//  FSM states: IDLE, RAM_RD, CAM_WAIT, DONE.
//   IDLE, RAM write: RAM written at edge; StallM=0; stay IDLE; zero stall cycles.
//   IDLE, RAM read:
//    - StallM=1 (combinational) for one cycle, then -> RAM_RD.
//   RAM_RD:
//    - ReadDataM = RAM word.
//    - StallM=0 so pipeline advances; -> IDLE. Load latency 2 cycles, 1 stall.
//   IDLE, cam access (read or write):
//    - StallM=1; latch cam_addr/cam_we/cam_wdata; cam_req=1 from next cycle; cnt=0; -> CAM_WAIT.
//   CAM_WAIT: StallM=1; cam_req/addr/we/wdata stable; cnt++ each cycle.
//    - On cam_ack: ReadDataM<=cam_rdata (reads only); cam_req<=0; -> DONE.
//    - Timeout (cnt==TIMEOUT-1, no ack): cam_req<=0; err flag set; -> DONE.
//      If a read, ReadDataM<=32'hDEAD_BEEF.
//    - cam_ack in the same cycle as the timeout: ack wins, no error.
//   DONE: StallM=0; ErrM=err flag (1 cycle); clear flag; -> IDLE.
//  Other rules:
//   - cam_ack outside CAM_WAIT is ignored.
//   - ReadDataM holds its last value when not updated; writes never modify it.
//   - No request in IDLE: StallM=0, outputs unchanged.
// TESTING
//  1 Write: SW 0x1234_5678 @0x40, then LW @0x40.
//    -> zero stall cycles on the write.
//    -> StallM high exactly 1 cycle on the load, then ReadDataM=0x1234_5678.
//  2 Wrap: SW 0xA5A5_A5A5 @0x0 (ADDR_BITS=10), then LW @0x1000.
//    -> ReadDataM=0xA5A5_A5A5.
//    -> AddrM[1:0]=2'b11 gives the same word.
//  3 Cam read @0x0001_0008, ack after 3 cycles with rdata 0xCAFE_0001.
//    -> cam_req high 3 cycles, then ReadDataM=0xCAFE_0001.
//    -> StallM high 4 cycles, then low for the DONE cycle; ErrM=0.
//  4 Cam read, no ack (TIMEOUT=16).
//    -> cam_req high 16 cycles.
//    -> ReadDataM=0xDEAD_BEEF; ErrM pulses 1 cycle in DONE.
//    Variant: ack on the 16th cycle -> rdata returned, ErrM=0.
//  5 Reset at cycle 2 of CAM_WAIT.
//    -> next cycle: cam_req=0, StallM=0, ReadDataM=0.
//    -> a later cam_ack causes no state change.
//  6 MemReadM=MemWriteM=1 @0x80 with WriteDataM=7, then LW @0x80.
//    -> first access is a zero-stall write; ReadDataM=7 after the load.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data-memory controller for the memory stage.
// Serves loads/stores from an internal word RAM (synchronous read) or from a
// camera/peripheral window reached through a req/ack handshake, and holds the
// pipeline with StallM while an access is outstanding.
module data_mem_ctrl #(
    parameter int unsigned ADDR_BITS = 10,
    parameter logic [31:0] CAM_BASE  = 32'h0001_0000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] AddrM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        ErrM,
    output logic        cam_req,
    output logic        cam_we,
    output logic [31:0] cam_addr,
    output logic [31:0] cam_wdata,
    input  logic        cam_ack,
    input  logic [31:0] cam_rdata
);

    localparam int unsigned DEPTH    = 32'd1 << ADDR_BITS;
    localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAM_RD   = 2'd1,
        CAM_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Command held on the camera port for the whole handshake
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cam_cmd_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_t               state_q;
    state_t               state_d;
    cam_cmd_t             cam_cmd_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [31:0]          mem [DEPTH];
    logic [ADDR_BITS-1:0] ram_idx;
    logic                 is_cam;
    logic                 ram_we;
    logic                 ram_rd;
    logic                 cam_start;
    logic                 cam_done_ack;
    logic                 cam_timeout;

    // Address decode: word index aliases for any address below the camera window
    assign ram_idx = AddrM[ADDR_BITS+1:2];
    assign is_cam  = (AddrM >= CAM_BASE);

    assign cam_we    = cam_cmd_q.we;
    assign cam_addr  = cam_cmd_q.addr;
    assign cam_wdata = cam_cmd_q.wdata;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, stall and datapath strobes; a simultaneous read+write is a write
    always_comb begin
        state_d      = state_q;
        StallM       = 1'b0;
        ram_we       = 1'b0;
        ram_rd       = 1'b0;
        cam_start    = 1'b0;
        cam_done_ack = 1'b0;
        cam_timeout  = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemWriteM && !is_cam) begin
                    ram_we = 1'b1;
                end else if (MemReadM && !is_cam) begin
                    StallM  = 1'b1;
                    ram_rd  = 1'b1;
                    state_d = RAM_RD;
                end else if ((MemReadM || MemWriteM) && is_cam) begin
                    StallM    = 1'b1;
                    cam_start = 1'b1;
                    state_d   = CAM_WAIT;
                end
            end
            RAM_RD: begin
                state_d = IDLE;
            end
            CAM_WAIT: begin
                StallM = 1'b1;
                if (cam_ack) begin
                    cam_done_ack = 1'b1;
                    state_d      = DONE;
                end else if (cnt_q == LAST_CNT) begin
                    cam_timeout = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (reset) begin
            StallM       = 1'b0;
            ram_we       = 1'b0;
            ram_rd       = 1'b0;
            cam_start    = 1'b0;
            cam_done_ack = 1'b0;
            cam_timeout  = 1'b0;
        end
    end

    // Internal word RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_idx] <= WriteDataM;
        end
    end

    // Load data register: RAM sync read, camera read data, or error pattern
    always_ff @(posedge clk) begin
        if (reset) begin
            ReadDataM <= '0;
        end else if (ram_rd) begin
            ReadDataM <= mem[ram_idx];
        end else if (cam_done_ack && !cam_cmd_q.we) begin
            ReadDataM <= cam_rdata;
        end else if (cam_timeout && !cam_cmd_q.we) begin
            ReadDataM <= ERR_DATA;
        end
    end

    // Camera request and command latch, dropped on ack or timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            cam_req   <= 1'b0;
            cam_cmd_q <= '0;
        end else if (cam_start) begin
            cam_req   <= 1'b1;
            cam_cmd_q <= '{we: MemWriteM, addr: AddrM, wdata: WriteDataM};
        end else if (cam_done_ack || cam_timeout) begin
            cam_req   <= 1'b0;
        end
    end

    // Wait-cycle counter for the camera timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (cam_start) begin
            cnt_q <= '0;
        end else if (state_q == CAM_WAIT) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Error flag: set on timeout, visible for the single DONE cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            ErrM <= 1'b0;
        end else if (cam_timeout) begin
            ErrM <= 1'b1;
        end else if (state_q == DONE) begin
            ErrM <= 1'b0;
        end
    end

endmodule
